sce_mac_sched: RTL and testbench

- Time-multiplexed scheduler for the symmetrical-component (sequence) decomposer.
- Accepts one three-phase sample per valid/ready handshake and keeps a one-sample history per phase.
- Runs one signed multiplier and a 32-bit accumulator through a fixed 13-step MAC schedule to form the three numerators.
- Shares one external sequential divider, issuing three divide requests per sample; emits saturated Vpos/Vneg/Vzero with a one-cycle valid strobe.

---
 rtl/sce_mac_sched.sv | 257 +++++++++++++++++++++++++
 tb/tb_sce_mac_sched.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sce_mac_sched.sv
// Time-multiplexed MAC and shared-divider scheduler for the symmetrical-component decomposer.
// One sample is accepted per IDLE visit, then 13 MAC steps form three numerators and three divides are issued.
module sce_mac_sched #(
  parameter int M  = 14,
  parameter int CF = 1000,
  parameter int PB = 3853,
  parameter int ZB = 4439,
  parameter int PC = 4853,
  parameter int ZC = 4439
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_hist,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [M-1:0] Va,
  input  logic signed [M-1:0] Vb,
  input  logic signed [M-1:0] Vc,
  output logic                div_start,
  output logic signed [31:0]  div_num,
  input  logic                div_done,
  input  logic signed [31:0]  div_quot,
  output logic signed [M-1:0] Vpos,
  output logic signed [M-1:0] Vneg,
  output logic signed [M-1:0] Vzero,
  output logic [2:0]          out_sat,
  output logic                out_valid
);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DIV} state_t;

  localparam logic signed [31:0] MAXQ = (32'sd1 <<< (M-1)) - 32'sd1;
  localparam logic signed [31:0] MINQ = -(32'sd1 <<< (M-1));

  state_t state_q, state_d;
  logic signed [M-1:0] cur_a_q, cur_b_q, cur_c_q, prev_b_q, prev_c_q;
  logic signed [M-1:0] cur_a_d, cur_b_d, cur_c_d, prev_b_d, prev_c_d;
  logic signed [M-1:0] op_a2_q, op_b2_q, op_c2_q, op_b1_q, op_c1_q;
  logic signed [M-1:0] op_a2_d, op_b2_d, op_c2_d, op_b1_d, op_c1_d;
  logic [3:0]          step_q, step_d;
  logic signed [31:0]  acc1_q, acc2_q, acc3_q, acc1_d, acc2_d, acc3_d;
  logic [1:0]          div_idx_q, div_idx_d;
  logic                wait_q, wait_d;
  logic signed [31:0]  q1_q, q2_q, q1_d, q2_d;
  logic signed [M-1:0] vpos_q, vneg_q, vzero_q, vpos_d, vneg_d, vzero_d;
  logic [2:0]          sat_q, sat_d;
  logic                valid_q, valid_d;

  logic                accept;
  logic signed [31:0]  coef, opnd_x, prod, term;
  logic signed [M-1:0] opnd;
  logic                neg;
  logic [1:0]          tgt;
  logic [M:0]          s1, s2, s3;

  // Returns {clipped, value} with the quotient limited to the M-bit signed range.
  function automatic logic [M:0] sat_fn(input logic signed [31:0] q);
    if (q > MAXQ)      return {1'b1, MAXQ[M-1:0]};
    else if (q < MINQ) return {1'b1, MINQ[M-1:0]};
    else               return {1'b0, q[M-1:0]};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cur_a_q   <= '0;
      cur_b_q   <= '0;
      cur_c_q   <= '0;
      prev_b_q  <= '0;
      prev_c_q  <= '0;
      op_a2_q   <= '0;
      op_b2_q   <= '0;
      op_c2_q   <= '0;
      op_b1_q   <= '0;
      op_c1_q   <= '0;
      step_q    <= '0;
      acc1_q    <= '0;
      acc2_q    <= '0;
      acc3_q    <= '0;
      div_idx_q <= '0;
      wait_q    <= 1'b0;
      q1_q      <= '0;
      q2_q      <= '0;
      vpos_q    <= '0;
      vneg_q    <= '0;
      vzero_q   <= '0;
      sat_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_a_q   <= cur_a_d;
      cur_b_q   <= cur_b_d;
      cur_c_q   <= cur_c_d;
      prev_b_q  <= prev_b_d;
      prev_c_q  <= prev_c_d;
      op_a2_q   <= op_a2_d;
      op_b2_q   <= op_b2_d;
      op_c2_q   <= op_c2_d;
      op_b1_q   <= op_b1_d;
      op_c1_q   <= op_c1_d;
      step_q    <= step_d;
      acc1_q    <= acc1_d;
      acc2_q    <= acc2_d;
      acc3_q    <= acc3_d;
      div_idx_q <= div_idx_d;
      wait_q    <= wait_d;
      q1_q      <= q1_d;
      q2_q      <= q2_d;
      vpos_q    <= vpos_d;
      vneg_q    <= vneg_d;
      vzero_q   <= vzero_d;
      sat_q     <= sat_d;
      valid_q   <= valid_d;
    end
  end

  // MAC schedule: steps 0-4 build num1, 5-9 num2, 10-12 num3.
  always_comb begin
    coef = '0;
    opnd = '0;
    neg  = 1'b0;
    tgt  = 2'd2;
    unique case (step_q)
      4'd0:  begin coef = 32'(CF); opnd = op_a2_q; tgt = 2'd0; end
      4'd1:  begin coef = 32'(PB); opnd = op_b2_q; tgt = 2'd0; end
      4'd2:  begin coef = 32'(ZC); opnd = op_c1_q; tgt = 2'd0; end
      4'd3:  begin coef = 32'(ZB); opnd = op_b1_q; tgt = 2'd0; neg = 1'b1; end
      4'd4:  begin coef = 32'(PC); opnd = op_c2_q; tgt = 2'd0; neg = 1'b1; end
      4'd5:  begin coef = 32'(CF); opnd = op_a2_q; tgt = 2'd1; end
      4'd6:  begin coef = 32'(ZC); opnd = op_b1_q; tgt = 2'd1; end
      4'd7:  begin coef = 32'(PB); opnd = op_c2_q; tgt = 2'd1; end
      4'd8:  begin coef = 32'(PC); opnd = op_b2_q; tgt = 2'd1; neg = 1'b1; end
      4'd9:  begin coef = 32'(ZB); opnd = op_c1_q; tgt = 2'd1; neg = 1'b1; end
      4'd10: begin coef = 32'(CF); opnd = op_a2_q; end
      4'd11: begin coef = 32'(CF); opnd = op_b2_q; end
      4'd12: begin coef = 32'(CF); opnd = op_c2_q; end
      default: ;
    endcase
    opnd_x = {{(32-M){opnd[M-1]}}, opnd};
    prod   = coef * opnd_x;
    term   = neg ? -prod : prod;
  end

  always_comb begin
    state_d   = state_q;
    cur_a_d   = cur_a_q;
    cur_b_d   = cur_b_q;
    cur_c_d   = cur_c_q;
    prev_b_d  = prev_b_q;
    prev_c_d  = prev_c_q;
    op_a2_d   = op_a2_q;
    op_b2_d   = op_b2_q;
    op_c2_d   = op_c2_q;
    op_b1_d   = op_b1_q;
    op_c1_d   = op_c1_q;
    step_d    = step_q;
    acc1_d    = acc1_q;
    acc2_d    = acc2_q;
    acc3_d    = acc3_q;
    div_idx_d = div_idx_q;
    wait_d    = wait_q;
    q1_d      = q1_q;
    q2_d      = q2_q;
    vpos_d    = vpos_q;
    vneg_d    = vneg_q;
    vzero_d   = vzero_q;
    sat_d     = sat_q;
    valid_d   = 1'b0;
    div_start = 1'b0;
    in_ready  = (state_q == S_IDLE) && !rst;
    accept    = in_ready && in_valid;
    s1        = sat_fn(q1_q);
    s2        = sat_fn(q2_q);
    s3        = sat_fn(div_quot);

    if (accept) begin
      cur_a_d  = Va;
      cur_b_d  = Vb;
      cur_c_d  = Vc;
      prev_b_d = clr_hist ? '0 : cur_b_q;
      prev_c_d = clr_hist ? '0 : cur_c_q;
    end else if (clr_hist) begin
      cur_a_d  = '0;
      cur_b_d  = '0;
      cur_c_d  = '0;
      prev_b_d = '0;
      prev_c_d = '0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_a2_d = Va;
          op_b2_d = Vb;
          op_c2_d = Vc;
          op_b1_d = clr_hist ? '0 : cur_b_q;
          op_c1_d = clr_hist ? '0 : cur_c_q;
          acc1_d  = '0;
          acc2_d  = '0;
          acc3_d  = '0;
          step_d  = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        unique case (tgt)
          2'd0:    acc1_d = acc1_q + term;
          2'd1:    acc2_d = acc2_q + term;
          default: acc3_d = acc3_q + term;
        endcase
        step_d = step_q + 4'd1;
        if (step_q == 4'd12) begin
          div_idx_d = '0;
          wait_d    = 1'b0;
          state_d   = S_DIV;
        end
      end
      S_DIV: begin
        if (!wait_q) begin
          div_start = 1'b1;
          wait_d    = 1'b1;
        end else if (div_done) begin
          wait_d    = 1'b0;
          div_idx_d = div_idx_q + 2'd1;
          unique case (div_idx_q)
            2'd0: q1_d = div_quot;
            2'd1: q2_d = div_quot;
            default: begin
              vpos_d  = s1[M-1:0];
              vneg_d  = s2[M-1:0];
              vzero_d = s3[M-1:0];
              sat_d   = {s3[M], s2[M], s1[M]};
              valid_d = 1'b1;
              state_d = S_IDLE;
            end
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    unique case (div_idx_q)
      2'd0:    div_num = acc1_q;
      2'd1:    div_num = acc2_q;
      default: div_num = acc3_q;
    endcase
  end

  assign Vpos      = vpos_q;
  assign Vneg      = vneg_q;
  assign Vzero     = vzero_q;
  assign out_sat   = sat_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_sce_mac_sched.sv
// Scoreboard bench for sce_mac_sched: a behavioural divider answers each request after lat cycles,
// and every accepted sample pushes its expected numerators and saturated results.
module tb_sce_mac_sched;
  localparam int M = 14;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                clr_hist = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic signed [M-1:0] Va = '0, Vb = '0, Vc = '0;
  logic                div_start;
  logic signed [31:0]  div_num;
  logic                div_done = 1'b0;
  logic signed [31:0]  div_quot = '0;
  logic signed [M-1:0] Vpos, Vneg, Vzero;
  logic [2:0]          out_sat;
  logic                out_valid;

  sce_mac_sched #(.M(M)) dut (
    .clk(clk), .rst(rst), .clr_hist(clr_hist), .in_valid(in_valid), .in_ready(in_ready),
    .Va(Va), .Vb(Vb), .Vc(Vc), .div_start(div_start), .div_num(div_num),
    .div_done(div_done), .div_quot(div_quot), .Vpos(Vpos), .Vneg(Vneg), .Vzero(Vzero),
    .out_sat(out_sat), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int n1, n2, n3;
    int vp, vn, vz;
    logic [2:0] sat;
  } exp_t;

  exp_t exp_q[$];
  int   dnum_q[$];
  int   dcyc_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   lat = 1;
  int   acc_cyc = 0;
  int   h_a = 0, h_b = 0, h_c = 0;

  // Divider stand-in: answers each request lat cycles later with num/3000 truncated.
  initial begin
    forever begin
      @(negedge clk);
      if (div_start === 1'b1) begin
        int n;
        n = div_num;
        dnum_q.push_back(n);
        dcyc_q.push_back(cyc);
        repeat (lat) @(posedge clk);
        #1 div_done = 1'b1;
        div_quot = n / 3000;
        @(posedge clk);
        #1 div_done = 1'b0;
      end
    end
  end

  function automatic int clipq(input int q, output logic c);
    int lo, hi;
    lo = -(1 << (M-1));
    hi = (1 << (M-1)) - 1;
    c = 1'b0;
    if (q > hi) begin c = 1'b1; return hi; end
    if (q < lo) begin c = 1'b1; return lo; end
    return q;
  endfunction

  function automatic void model_accept(input int a2, input int b2, input int c2, input logic clr);
    exp_t e;
    int b1, c1;
    logic k0, k1, k2;
    b1 = clr ? 0 : h_b;
    c1 = clr ? 0 : h_c;
    e.n1 = 1000*a2 + 3853*b2 + 4439*c1 - 4439*b1 - 4853*c2;
    e.n2 = 1000*a2 + 4439*b1 + 3853*c2 - 4853*b2 - 4439*c1;
    e.n3 = 1000*a2 + 1000*b2 + 1000*c2;
    e.vp = clipq(e.n1 / 3000, k0);
    e.vn = clipq(e.n2 / 3000, k1);
    e.vz = clipq(e.n3 / 3000, k2);
    e.sat = {k2, k1, k0};
    exp_q.push_back(e);
    h_a = a2;
    h_b = b2;
    h_c = c2;
  endfunction

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    h_a = 0; h_b = 0; h_c = 0;
    exp_q.delete();
    dnum_q.delete();
    dcyc_q.delete();
  endtask

  task automatic send(input int va, input int vb, input int vc, input logic clr);
    bit got;
    got = 0;
    @(posedge clk);
    #1 in_valid = 1'b1;
    Va = va[M-1:0];
    Vb = vb[M-1:0];
    Vc = vc[M-1:0];
    clr_hist = clr;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin got = 1; break; end
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL accept: in_ready never rose, got %b want 1", in_ready);
    end
    acc_cyc = cyc;
    model_accept(va, vb, vc, clr);
    @(posedge clk);
    #1 in_valid = 1'b0;
    clr_hist = 1'b0;
  endtask

  // Scoreboard consumer: waits for the result strobe, pops the expectation and compares.
  task automatic drain_result(input string tag);
    bit   got;
    exp_t e;
    int   en[3];
    int   n, c;
    got = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin got = 1; break; end
    end
    vectors++;
    if (!got || exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s.out_valid: got none want pulse", tag);
      return;
    end
    e = exp_q.pop_front();
    vectors += 5;
    if (cyc !== acc_cyc + 17 + 3*lat) begin
      miscompares++;
      $display("FAIL %s.cycle: got %0d want %0d", tag, cyc - acc_cyc, 17 + 3*lat);
    end
    if (Vpos !== e.vp) begin
      miscompares++;
      $display("FAIL %s.vpos: got %0d want %0d", tag, Vpos, e.vp);
    end
    if (Vneg !== e.vn) begin
      miscompares++;
      $display("FAIL %s.vneg: got %0d want %0d", tag, Vneg, e.vn);
    end
    if (Vzero !== e.vz) begin
      miscompares++;
      $display("FAIL %s.vzero: got %0d want %0d", tag, Vzero, e.vz);
    end
    if (out_sat !== e.sat) begin
      miscompares++;
      $display("FAIL %s.out_sat: got %b want %b", tag, out_sat, e.sat);
    end
    en = '{e.n1, e.n2, e.n3};
    vectors++;
    if (dnum_q.size() != 3) begin
      miscompares++;
      $display("FAIL %s.div_count: got %0d want 3", tag, dnum_q.size());
      dnum_q.delete();
      dcyc_q.delete();
      return;
    end
    for (int i = 0; i < 3; i++) begin
      n = dnum_q.pop_front();
      c = dcyc_q.pop_front();
      vectors += 2;
      if (n !== en[i]) begin
        miscompares++;
        $display("FAIL %s.div_num%0d: got %0d want %0d", tag, i, n, en[i]);
      end
      if (c !== acc_cyc + 14 + i*(lat + 1)) begin
        miscompares++;
        $display("FAIL %s.div_start%0d: got cycle %0d want %0d", tag, i, c - acc_cyc, 14 + i*(lat + 1));
      end
    end
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors += 4;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset.in_ready: got %b want 0", in_ready);
    end
    if (out_valid !== 1'b0 || div_start !== 1'b0) begin
      miscompares++;
      $display("FAIL reset.strobes: got %b%b want 00", out_valid, div_start);
    end
    if (Vpos !== 0 || Vneg !== 0 || Vzero !== 0) begin
      miscompares++;
      $display("FAIL reset.outputs: got %0d %0d %0d want 0 0 0", Vpos, Vneg, Vzero);
    end
    if (out_sat !== 3'b000) begin
      miscompares++;
      $display("FAIL reset.out_sat: got %b want 000", out_sat);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    in_valid = 1'b0;
    h_a = 0; h_b = 0; h_c = 0;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset.idle_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_basic();
    lat = 1;
    send(300, 300, 300, 1'b0);
    drain_result("basic");
    send(300, 300, 300, 1'b0);
    drain_result("repeat");
  endtask

  task automatic test_trunc();
    lat = 1;
    do_reset();
    send(0, 0, -1, 1'b0);
    drain_result("trunc");
    send(-1, 2, 7, 1'b0);
    drain_result("trunc2");
  endtask

  task automatic test_sat();
    lat = 3;
    do_reset();
    send(8191, -8192, 8191, 1'b0);
    drain_result("sat_hi");
    send(-8192, 8191, -8192, 1'b0);
    drain_result("sat_lo");
  endtask

  task automatic test_back_to_back();
    bit bad_ready, bad_valid;
    lat = 5;
    do_reset();
    @(posedge clk);
    #1 in_valid = 1'b1;
    Va = 14'sd300; Vb = 14'sd300; Vc = 14'sd300;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b.first_accept: got %b want 1", in_ready);
    end
    acc_cyc = cyc;
    model_accept(300, 300, 300, 1'b0);
    @(posedge clk);
    #1 Va = -14'sd1200; Vb = 14'sd450; Vc = 14'sd77;
    bad_ready = 0;
    bad_valid = 0;
    for (int k = 1; k <= 31; k++) begin
      @(negedge clk);
      if (in_ready !== 1'b0) bad_ready = 1;
      if (out_valid !== 1'b0) bad_valid = 1;
    end
    vectors += 2;
    if (bad_ready) begin
      miscompares++;
      $display("FAIL b2b.busy_ready: got 1 want 0 during cycles 1..31");
    end
    if (bad_valid) begin
      miscompares++;
      $display("FAIL b2b.early_valid: got 1 want 0 during cycles 1..31");
    end
    drain_result("b2b_first");
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b.second_accept: got %b want 1 at cycle %0d", in_ready, cyc - acc_cyc);
    end
    acc_cyc = cyc;
    model_accept(-1200, 450, 77, 1'b0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b.pulse_width: got valid=%b ready=%b want 0 0", out_valid, in_ready);
    end
    drain_result("b2b_second");
  endtask

  task automatic test_abort();
    int nvalid, nstart;
    lat = 5;
    do_reset();
    send(1000, -2000, 500, 1'b0);
    repeat (15) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    h_a = 0; h_b = 0; h_c = 0;
    exp_q.delete();
    nvalid = 0;
    nstart = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) nvalid++;
      if (div_start === 1'b1) nstart++;
    end
    vectors += 3;
    if (nvalid != 0) begin
      miscompares++;
      $display("FAIL abort.out_valid: got %0d pulses want 0", nvalid);
    end
    if (nstart != 0 || dnum_q.size() != 1) begin
      miscompares++;
      $display("FAIL abort.div_start: got %0d late/%0d total want 0/1", nstart, dnum_q.size());
    end
    if (Vpos !== 0 || Vneg !== 0 || Vzero !== 0) begin
      miscompares++;
      $display("FAIL abort.outputs: got %0d %0d %0d want 0 0 0", Vpos, Vneg, Vzero);
    end
    dnum_q.delete();
    dcyc_q.delete();
    send(300, 300, 300, 1'b0);
    drain_result("after_abort");
  endtask

  task automatic test_clr_hist();
    lat = 2;
    do_reset();
    send(1000, -2000, 500, 1'b0);
    drain_result("clr_pre");
    send(300, 300, 300, 1'b1);
    drain_result("clr_accept");
    send(-700, 1200, -50, 1'b0);
    #1 clr_hist = 1'b1;
    @(posedge clk);
    #1 clr_hist = 1'b0;
    h_a = 0; h_b = 0; h_c = 0;
    drain_result("clr_busy");
    send(100, 200, 300, 1'b0);
    drain_result("clr_after");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_trunc();
    test_sat();
    test_back_to_back();
    test_abort();
    test_clr_hist();
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
